// File: rtl/cpu_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_sched_pkg
//  Description : Shared constants for the least-loaded CPU scheduler:
//                FSM state encoding and load counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_sched_pkg;

    // Load counter width; loads are unsigned and only ever compared
    localparam int LOAD_W = 32;

    // FSM state encoding
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SCAN  = 2'd1;
    localparam logic [1:0] GRANT = 2'd2;

endpackage
`default_nettype wire

// File: rtl/cpu_load_scheduler_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_32bit
//  Description : Unsigned 32-bit magnitude comparator with lt/eq/gt flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmp_32bit
    import cpu_sched_pkg::*;
(
    input  logic [LOAD_W-1:0] a,
    input  logic [LOAD_W-1:0] b,
    output logic              lt,
    output logic              eq,
    output logic              gt
);

    // Pure combinational unsigned compare
    always_comb begin
        lt = (a <  b);
        eq = (a == b);
        gt = (a >  b);
    end

endmodule
`default_nettype wire

// File: rtl/cpu_load_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_load_scheduler
//  Description : Selects the least-loaded enabled CPU by scanning a snapshot
//                of the per-CPU load counters one entry per cycle through a
//                single shared comparator. Result offered on a valid/ready
//                grant interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_load_scheduler
    import cpu_sched_pkg::*;
#(
    parameter  int N_CPU = 4,
    localparam int IDX_W = $clog2(N_CPU)
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [N_CPU*LOAD_W-1:0] load_flat,
    input  logic [N_CPU-1:0]        cpu_en,
    output logic                    grant_valid,
    input  logic                    grant_ready,
    output logic [IDX_W-1:0]        grant_idx,
    output logic [LOAD_W-1:0]       grant_load,
    output logic                    grant_none,
    output logic                    busy
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N_CPU - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;

    logic [LOAD_W-1:0] r_snap [N_CPU];
    logic [N_CPU-1:0]  r_en;
    logic [IDX_W-1:0]  r_idx;
    logic              r_last;       // all entries compared, finalize next
    logic [LOAD_W-1:0] r_best_load;
    logic [IDX_W-1:0]  r_best_idx;
    logic              r_best_valid;

    logic [IDX_W-1:0]  r_grant_idx;
    logic [LOAD_W-1:0] r_grant_load;
    logic              r_grant_none;

    logic [LOAD_W-1:0] w_cur_load;
    logic              w_cur_en;
    logic              w_lt;
    logic              w_eq;
    logic              w_gt;
    logic              w_take;

    assign w_cur_load = r_snap[r_idx];
    assign w_cur_en   = r_en[r_idx];

    // Single shared comparator: current snapshot entry against running best
    cmp_32bit u_cmp (
        .a  (w_cur_load),
        .b  (r_best_load),
        .lt (w_lt),
        .eq (w_eq),
        .gt (w_gt)
    );

    // Strictly lower wins, so on a tie the earlier (lower) index is kept
    assign w_take = (r_state == SCAN) && !r_last && w_cur_en &&
                    (!r_best_valid || w_lt);

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        grant_valid = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_state_nxt = SCAN;
            end
            SCAN: begin
                busy = 1'b1;
                if (r_last) w_state_nxt = GRANT;
            end
            GRANT: begin
                busy        = 1'b1;
                grant_valid = 1'b1;
                if (grant_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Snapshot capture, sequential scan and grant register load
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_CPU; k++) r_snap[k] <= '0;
            r_en         <= '0;
            r_idx        <= '0;
            r_last       <= 1'b0;
            r_best_load  <= '0;
            r_best_idx   <= '0;
            r_best_valid <= 1'b0;
            r_grant_idx  <= '0;
            r_grant_load <= '0;
            r_grant_none <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        for (int k = 0; k < N_CPU; k++)
                            r_snap[k] <= load_flat[k*LOAD_W +: LOAD_W];
                        r_en         <= cpu_en;
                        r_idx        <= '0;
                        r_last       <= 1'b0;
                        r_best_load  <= '0;
                        r_best_idx   <= '0;
                        r_best_valid <= 1'b0;
                    end
                end
                SCAN: begin
                    if (!r_last) begin
                        if (w_take) begin
                            r_best_load  <= w_cur_load;
                            r_best_idx   <= r_idx;
                            r_best_valid <= 1'b1;
                        end
                        if (r_idx == c_last_idx) r_last <= 1'b1;
                        else                     r_idx  <= r_idx + IDX_W'(1);
                    end else begin
                        // Best registers stay zero when nothing was enabled
                        r_grant_idx  <= r_best_idx;
                        r_grant_load <= r_best_load;
                        r_grant_none <= !r_best_valid;
                    end
                end
                default: ;
            endcase
        end
    end

    assign grant_idx  = r_grant_idx;
    assign grant_load = r_grant_load;
    assign grant_none = r_grant_none;

    // Comparator sanity: exactly one relation holds while scanning
    always_ff @(posedge clk) begin
        if (!rst && r_state == SCAN)
            assert ($onehot({w_lt, w_eq, w_gt}));
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_load_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_load_scheduler
//  Description : Directed self-checking bench for cpu_load_scheduler, N_CPU=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_load_scheduler;

    localparam int N_CPU = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [127:0] load_flat;
    logic [3:0]   cpu_en;
    logic         grant_valid;
    logic         grant_ready;
    logic [1:0]   grant_idx;
    logic [31:0]  grant_load;
    logic         grant_none;
    logic         busy;

    int n_vec = 0;
    int n_bad = 0;

    cpu_load_scheduler #(.N_CPU(N_CPU)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .load_flat   (load_flat),
        .cpu_en      (cpu_en),
        .grant_valid (grant_valid),
        .grant_ready (grant_ready),
        .grant_idx   (grant_idx),
        .grant_load  (grant_load),
        .grant_none  (grant_none),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample/drive point is 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE and wait (bounded) for grant_valid.
    // lat = number of edges after the acceptance edge until grant_valid seen.
    task automatic do_req(input logic [127:0] loads, input logic [3:0] en,
                          input bit scramble, output int lat);
        chk("req_ready_before_req", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        load_flat = loads;
        cpu_en    = en;
        step();                       // acceptance edge
        req_valid = 1'b0;
        lat = 0;
        while (!grant_valid && lat < 40) begin
            if (scramble) begin
                // Small loads that would win if they leaked into the scan
                load_flat = {32'(lat), 32'd1, 32'(lat + 2), 32'd0};
                cpu_en    = 4'(lat);
                chk("req_ready_low_in_scan", 32'(req_ready), 32'd0);
            end
            step();
            lat++;
        end
    endtask

    int lat;
    int aborted_grants;
    int grants, accepts, last_fall, gap0, gap1;
    bit ready_prev, gv_prev;

    initial begin
        rst         = 1'b1;
        req_valid   = 1'b0;
        load_flat   = '0;
        cpu_en      = '0;
        grant_ready = 1'b1;
        step();
        step();

        // ---- Reset state
        chk("rst_req_ready",   32'(req_ready),   32'd1);
        chk("rst_grant_valid", 32'(grant_valid), 32'd0);
        chk("rst_grant_idx",   32'(grant_idx),   32'd0);
        chk("rst_grant_load",  grant_load,       32'd0);
        chk("rst_grant_none",  32'(grant_none),  32'd0);
        chk("rst_busy",        32'(busy),        32'd0);
        rst = 1'b0;
        step();

        // ---- Basic minimum: {100,40,75,41} -> cpu1, load 40, 5 cycles
        do_req({32'd41, 32'd75, 32'd40, 32'd100}, 4'b1111, 1'b0, lat);
        chk("basic_latency", 32'(lat),        32'd5);
        chk("basic_idx",     32'(grant_idx),  32'd1);
        chk("basic_load",    grant_load,      32'd40);
        chk("basic_none",    32'(grant_none), 32'd0);
        step();
        chk("basic_gv_drop",   32'(grant_valid), 32'd0);
        chk("basic_ready_back", 32'(req_ready),  32'd1);

        // ---- Tie-break: {9,5,5,5} -> lowest of the tied indices, cpu1
        do_req({32'd5, 32'd5, 32'd5, 32'd9}, 4'b1111, 1'b0, lat);
        chk("tie_idx",  32'(grant_idx), 32'd1);
        chk("tie_load", grant_load,     32'd5);
        step();

        // ---- Mask and extremes: only cpu1/cpu2 eligible
        do_req({32'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0}, 4'b0110, 1'b0, lat);
        chk("mask_idx",  32'(grant_idx),  32'd2);
        chk("mask_load", grant_load,      32'hFFFF_FFFE);
        chk("mask_none", 32'(grant_none), 32'd0);
        step();

        // ---- Empty mask
        do_req({32'd3, 32'd2, 32'd1, 32'd7}, 4'b0000, 1'b0, lat);
        chk("empty_none", 32'(grant_none), 32'd1);
        chk("empty_idx",  32'(grant_idx),  32'd0);
        chk("empty_load", grant_load,      32'd0);
        step();

        // ---- Single CPU enabled wins regardless of load
        do_req({32'hFFFF_FFFF, 32'd1, 32'd2, 32'd3}, 4'b1000, 1'b0, lat);
        chk("single_idx",  32'(grant_idx), 32'd3);
        chk("single_load", grant_load,     32'hFFFF_FFFF);
        step();

        // ---- Snapshot isolation and backpressure: {50,30,20,60} -> cpu2
        grant_ready = 1'b0;
        do_req({32'd60, 32'd20, 32'd30, 32'd50}, 4'b1111, 1'b1, lat);
        chk("snap_latency", 32'(lat), 32'd5);
        for (int s = 0; s < 7; s++) begin
            load_flat = '0;
            chk("stall_gv",    32'(grant_valid), 32'd1);
            chk("stall_idx",   32'(grant_idx),   32'd2);
            chk("stall_load",  grant_load,       32'd20);
            chk("stall_none",  32'(grant_none),  32'd0);
            chk("stall_ready", 32'(req_ready),   32'd0);
            step();
        end
        chk("stall_gv_end", 32'(grant_valid), 32'd1);
        grant_ready = 1'b1;
        step();
        chk("stall_release_gv",    32'(grant_valid), 32'd0);
        chk("stall_release_ready", 32'(req_ready),   32'd1);

        // ---- Reset during the second SCAN cycle
        req_valid = 1'b1;
        load_flat = {32'd4, 32'd3, 32'd2, 32'd1};
        cpu_en    = 4'b1111;
        step();                       // accepted
        req_valid = 1'b0;
        step();                       // now in second scan cycle
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_ready", 32'(req_ready),   32'd1);
        chk("abort_gv",    32'(grant_valid), 32'd0);
        chk("abort_busy",  32'(busy),        32'd0);
        aborted_grants = 0;
        for (int s = 0; s < 10; s++) begin
            if (grant_valid) aborted_grants++;
            step();
        end
        chk("abort_no_grant", 32'(aborted_grants), 32'd0);
        do_req({32'd8, 32'd6, 32'd7, 32'd9}, 4'b1111, 1'b0, lat);
        chk("post_abort_latency", 32'(lat),       32'd5);
        chk("post_abort_idx",     32'(grant_idx), 32'd2);
        chk("post_abort_load",    grant_load,     32'd6);
        step();

        // ---- Back-to-back: req_valid held high for 3 requests.
        // Handshake edge to next grant is N_CPU+2 cycles.
        load_flat = {32'd11, 32'd10, 32'd12, 32'd13};
        cpu_en    = 4'b1111;
        req_valid = 1'b1;
        grants = 0; accepts = 0; last_fall = -1; gap0 = -1; gap1 = -1;
        gv_prev = grant_valid;
        for (int c = 1; c <= 30; c++) begin
            ready_prev = req_ready;
            step();
            if (ready_prev && req_valid) begin
                accepts++;
                if (accepts == 3) req_valid = 1'b0;
            end
            if (grant_valid && !gv_prev) begin
                grants++;
                if (grants == 2) gap0 = c - last_fall;
                if (grants == 3) gap1 = c - last_fall;
                chk("b2b_idx", 32'(grant_idx), 32'd2);
            end
            if (!grant_valid && gv_prev) last_fall = c;
            gv_prev = grant_valid;
        end
        req_valid = 1'b0;
        chk("b2b_grants", 32'(grants), 32'd3);
        chk("b2b_gap0",   32'(gap0),   32'(N_CPU + 2));
        chk("b2b_gap1",   32'(gap1),   32'(N_CPU + 2));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
